// File: rtl/aes_pkg.sv
// aes_pkg: shared AES constants for the iterative datapath.
//   SBOX / INV_SBOX     : forward and inverse S-box byte tables
//   sb_state_e          : IDLE / BUSY / DONE states of the chunked SubBytes FSM
//   AES_STATE_BYTES     : bytes in one AES state
//   sbox_lookup()       : table lookup, forward or inverse by select bit
package aes_pkg;

  localparam int AES_STATE_BYTES = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } sb_state_e;

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [0:255] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] sbox_lookup(input logic [7:0] b, input logic inv);
    logic [7:0] r;
    if (inv) begin
      r = INV_SBOX[b];
    end else begin
      r = SBOX[b];
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_sbox_lane.sv
// aes_sbox_lane: one combinational S-box lane, shared with key expansion.
//   data_i : input byte
//   inv_i  : 0 = forward S-box, 1 = inverse S-box
//   data_o : substituted byte
module aes_sbox_lane
  import aes_pkg::*;
(
  input  logic [7:0] data_i,
  input  logic       inv_i,
  output logic [7:0] data_o
);

  assign data_o = sbox_lookup(data_i, inv_i);

endmodule

// File: rtl/sub_bytes_iter.sv
// sub_bytes_iter: iterative (Inv)SubBytes over an NBYTES-byte state, LANES
// bytes per cycle, lowest-indexed chunk first.
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid / in_ready  : input handshake; message and inv captured at accept
//   inv                  : 0 = SubBytes, 1 = InvSubBytes
//   message              : input state, byte i = message[8i+7:8i]
//   out_valid / out_ready: output handshake; result held until taken
//   Emessage             : substituted state, driven from the working register
module sub_bytes_iter
  import aes_pkg::*;
#(
  parameter int NBYTES = AES_STATE_BYTES,
  parameter int LANES  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  inv,
  input  logic [8*NBYTES-1:0]   message,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   Emessage
);

  localparam int W          = 8 * NBYTES;
  localparam int LW         = 8 * ((LANES < 1) ? 1 : LANES);
  localparam int LANES_SAFE = (LANES < 1) ? 1 : LANES;
  localparam int NCHUNK     = NBYTES / LANES_SAFE;
  localparam int CW         = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NCHUNK - 1);

  if ((LANES < 1) || ((NBYTES % LANES_SAFE) != 0)) begin : g_bad_params
    $fatal(1, "sub_bytes_iter: NBYTES must be a positive multiple of LANES");
  end

  sb_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            inv_q, inv_d;
  logic [W-1:0]    work_q, work_d;

  logic [31:0]     shift_s;
  logic [W-1:0]    shifted_s;
  logic [LW-1:0]   lanes_in_s;
  logic [LW-1:0]   lanes_out_s;
  logic [W-1:0]    merged_s;

  // Bring the current chunk down to bit 0 and splice the substituted bytes
  // back at the same offset; the shift avoids a variable-index part-select.
  assign shift_s    = 32'(cnt_q) * 32'(LW);
  assign shifted_s  = work_q >> shift_s;
  assign lanes_in_s = shifted_s[LW-1:0];
  assign merged_s   = (work_q & ~(W'({LW{1'b1}}) << shift_s)) | (W'(lanes_out_s) << shift_s);

  for (genvar l = 0; l < LANES_SAFE; l++) begin : g_lane
    aes_sbox_lane u_lane (
      .data_i (lanes_in_s[8*l +: 8]),
      .inv_i  (inv_q),
      .data_o (lanes_out_s[8*l +: 8])
    );
  end

  // Next-state logic: accept in IDLE, one chunk per cycle in BUSY, hold in DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    inv_d   = inv_q;
    work_d  = work_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = message;
          inv_d   = inv;
          cnt_d   = '0;
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        work_d = merged_s;
        // Counter saturates at the last chunk rather than wrapping.
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counter, latched mode and working register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      inv_q   <= 1'b0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      inv_q   <= inv_d;
      work_q  <= work_d;
    end
  end

  // Ready is masked while reset is asserted so nothing is offered during it.
  assign in_ready  = rst_n && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign Emessage  = work_q;

endmodule

// File: doc/sub_bytes_iter.md
Name: sub_bytes_iter

Overview:
- Sequential, parametrised successor to the combinational SubBytes stage.
- Applies the AES S-box (forward) or inverse S-box (InvSubBytes, selected per transaction) to an NBYTES-byte state.
- Uses LANES S-box instances per cycle, so area and latency can be traded.
- Sits between the AddRoundKey and ShiftRows stages of the iterative AES datapath, with valid/ready handshakes on both sides.

Parameters:
- NBYTES, 16, number of bytes in the state; must be a multiple of LANES.
- LANES, 4, S-box lanes applied per cycle; legal values are divisors of NBYTES (1, 2, 4, 8, 16 for the default).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  message and inv are valid
- in_ready  out  1  block can accept a new state
- inv  in  1  0 = forward SubBytes, 1 = InvSubBytes; sampled only at accept
- message  in  8*NBYTES  input state; byte i = message[8i+7:8i]
- out_valid  out  1  Emessage holds the completed result
- out_ready  in  1  consumer accepts the result
- Emessage  out  8*NBYTES  substituted state, byte-for-byte aligned with message

Behaviour:
- Reset: when rst_n=0 at a rising clk edge, the FSM goes to IDLE, the chunk counter goes to 0, and the latched inv goes to 0. Outputs: in_ready=0 during the reset cycle then 1 in IDLE; out_valid=0; Emessage=0.
- Reset asserted mid-operation (BUSY or DONE) aborts the transaction. No partial result is ever flagged valid.
- FSM states are IDLE, BUSY and DONE.
  - IDLE: in_ready=1. On in_valid=1: latch message into the working register, latch inv, clear the counter, go to BUSY.
  - BUSY: in_ready=0, out_valid=0. Each cycle, replace bytes [LANES*cnt .. LANES*cnt+LANES-1] with S(byte) or S^-1(byte), then increment cnt. When cnt = NBYTES/LANES-1, the last chunk is written and the FSM goes to DONE.
  - DONE: out_valid=1, in_ready=0. Emessage is stable. On out_ready=1, go to IDLE.
- Chunk order: lowest-indexed bytes first.
- Latency: the accept edge is edge 0; out_valid rises after edge N, where N = NBYTES/LANES. Default N=4; LANES=16 gives N=1.
- Throughput: one state per N+2 cycles maximum. There is no overlap of accept with DONE.
- in_valid while in_ready=0 is ignored. The producer must hold the data, per the standard valid/ready rule.
- out_ready while out_valid=0 has no effect. out_ready held low in DONE holds the result indefinitely.
- Emessage is driven directly from the working register. Its value while out_valid=0 carries no meaning (0 after reset). It must not change while out_valid=1.
- Changes to inv or message after accept do not affect the transaction in flight.
- The counter is log2(NBYTES/LANES) bits wide with a minimum of 1 bit. It never wraps past N-1.
- Elaboration check: a fatal error if NBYTES % LANES != 0 or LANES < 1.

Decomposition:
- Shared package aes_pkg holds:
  - SBOX[0:255] and INV_SBOX[0:255] byte constant tables;
  - the FSM state enum (IDLE, BUSY, DONE);
  - the AES_STATE_BYTES = 16 constant.
- Sub-module aes_sbox_lane: combinational, 8-bit in, inv select, 8-bit out, table lookup from aes_pkg. Instantiated LANES times in a generate loop.
- The same lane is reused by the key-expansion block.

Test Plan:
- Forward, defaults: message=0123456789ABCDEF0123456789ABCDEF, inv=0 -> Emessage=7C266E85A762BDDF7C266E85A762BDDF. out_valid rises exactly 4 cycles after accept.
- Inverse round-trip: feed 7C266E85A762BDDF7C266E85A762BDDF with inv=1 -> 0123456789ABCDEF0123456789ABCDEF. Also message=0 with inv=0 -> all bytes 63.
- FIPS-197 vector for LANES=1, 4 and 16: 00112233445566778899AABBCCDDEEFF -> 638293C31BFC33F5C4EEAC EA4BC12816 (no spaces: 638293C31BFC33F5C4EEACEA4BC12816). Latency is 16, 4 and 1 respectively.
- Back-pressure: hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, Emessage is unchanged, in_ready stays 0, and a new in_valid is ignored. Release -> IDLE on the next cycle.
- Reset mid-BUSY: assert rst_n=0 after 2 of 4 chunks -> next cycle out_valid=0, Emessage=0, in_ready=1 after reset release. A fresh 53 in byte 0 (rest 00) -> byte 0 = ED, rest 63.
- Stimulus hold: toggle inv and message during BUSY -> result matches the values latched at accept.
